// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with
// registered operands and a valid/ready response. Optional macro ALU_PERF_CNT_EN adds perf counters.
module alu_share_arbiter #(
   parameter int WIDTH  = 8,
   parameter int FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic [FUNC_W-1:0] req0_func,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   input  logic [FUNC_W-1:0] req1_func,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [WIDTH-1:0]  alu_res,
   input  logic              alu_zf,
   input  logic              alu_of,
   input  logic              alu_cf,
   input  logic              alu_sf,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [WIDTH-1:0]  rsp_res,
   output logic [3:0]        rsp_flags,
   output logic              busy
`ifdef ALU_PERF_CNT_EN
   ,
   output logic [15:0]       perf_ops,
   output logic [15:0]       perf_conflicts
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_reg, state_next;
   logic              prio_reg;
   logic              owner_reg;
   logic [WIDTH-1:0]  alu_a_reg, alu_b_reg;
   logic [FUNC_W-1:0] alu_func_reg;
   logic [WIDTH-1:0]  rsp_res_reg;
   logic [3:0]        rsp_flags_reg;
   logic              grant;
   logic              accept;
   logic              rsp_done;

   // Contested requests go to prio_reg; otherwise the lone valid requester wins.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b11)
         grant = prio_reg;
      else if (req_valid[1])
         grant = 1'b1;
   end

   assign accept   = (state_reg == ST_IDLE) && (|req_valid) && !rst;
   assign rsp_done = (state_reg == ST_RESP) && rsp_ready[owner_reg];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam logic IDX = (gi == 1);
         assign req_ready[gi] = accept && (grant == IDX);
         assign rsp_valid[gi] = (state_reg == ST_RESP) && (owner_reg == IDX);
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept)   state_next = ST_EXEC;
         ST_EXEC:               state_next = ST_RESP;
         ST_RESP: if (rsp_done) state_next = ST_IDLE;
         default:               state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         prio_reg      <= 1'b0;
         owner_reg     <= 1'b0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_func_reg  <= '0;
         rsp_res_reg   <= '0;
         rsp_flags_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  alu_a_reg    <= grant ? req1_a    : req0_a;
                  alu_b_reg    <= grant ? req1_b    : req0_b;
                  alu_func_reg <= grant ? req1_func : req0_func;
                  owner_reg    <= grant;
                  prio_reg     <= ~grant;
               end
            end
            ST_EXEC: begin
               rsp_res_reg   <= alu_res;
               rsp_flags_reg <= {alu_zf, alu_of, alu_cf, alu_sf};
            end
            default: ;
         endcase
      end
   end

   assign alu_a     = alu_a_reg;
   assign alu_b     = alu_b_reg;
   assign alu_func  = alu_func_reg;
   assign rsp_res   = rsp_res_reg;
   assign rsp_flags = rsp_flags_reg;
   assign busy      = (state_reg != ST_IDLE);

`ifdef ALU_PERF_CNT_EN
   logic [15:0] perf_ops_reg, perf_conflicts_reg;

   // Saturating: counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops_reg       <= '0;
         perf_conflicts_reg <= '0;
      end else begin
         if (rsp_done && (perf_ops_reg != 16'hFFFF))
            perf_ops_reg <= perf_ops_reg + 16'd1;
         if (accept && (req_valid == 2'b11) && (perf_conflicts_reg != 16'hFFFF))
            perf_conflicts_reg <= perf_conflicts_reg + 16'd1;
      end
   end

   assign perf_ops       = perf_ops_reg;
   assign perf_conflicts = perf_conflicts_reg;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a stub ALU; covers ALU_PERF_CNT_EN when defined.
module tb_alu_share_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid, req_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] req0_func, req1_func;
   logic [7:0] alu_a, alu_b, alu_res;
   logic [3:0] alu_func;
   logic       alu_zf, alu_of, alu_cf, alu_sf;
   logic [1:0] rsp_valid, rsp_ready;
   logic [7:0] rsp_res;
   logic [3:0] rsp_flags;
   logic       busy;
`ifdef ALU_PERF_CNT_EN
   logic [15:0] perf_ops, perf_conflicts;
`endif

   alu_share_arbiter #(.WIDTH(8), .FUNC_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
      .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_res(alu_res), .alu_zf(alu_zf), .alu_of(alu_of), .alu_cf(alu_cf), .alu_sf(alu_sf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_PERF_CNT_EN
      , .perf_ops(perf_ops), .perf_conflicts(perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   // Stub ALU: XOR for func 1, add otherwise.
   logic [8:0] sum9;
   always_comb begin
      sum9 = {1'b0, alu_a} + {1'b0, alu_b};
      if (alu_func == 4'd1) begin
         alu_res = alu_a ^ alu_b;
         alu_cf  = 1'b0;
      end else begin
         alu_res = sum9[7:0];
         alu_cf  = sum9[8];
      end
      alu_zf = (alu_res == 8'h00);
      alu_of = 1'b0;
      alu_sf = alu_res[7];
   end

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_grant[$];
   logic [11:0] exp_rsp0[$];
   logic [11:0] exp_rsp1[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compares accepts and response handshakes against the queues.
   int          acc_cyc = 0;
   bit          wait_rsp = 0;
   int          eg;
   logic [11:0] er;
   logic        r;
   always @(negedge clk) begin
      if (rst) begin
         wait_rsp = 0;
      end else begin
         if ((req_ready & req_valid) != 2'b00) begin
            chk("req_ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
            if (exp_grant.size() == 0) begin
               chk("unexpected_grant", {30'd0, req_ready}, 32'd0);
            end else begin
               eg = exp_grant.pop_front();
               chk("grant", {31'd0, req_ready[1]}, eg);
            end
            acc_cyc  = cyc;
            wait_rsp = 1;
         end
         if (rsp_valid != 2'b00) begin
            chk("rsp_valid_onehot", {31'd0, $onehot(rsp_valid)}, 32'd1);
            if (wait_rsp) begin
               chk("latency", cyc - acc_cyc, 32'd2);
               wait_rsp = 0;
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
               r = rsp_valid[1];
               $display("rsp req%0d res=%02h flags=%04b", r, rsp_res, rsp_flags);
               if ((r ? exp_rsp1.size() : exp_rsp0.size()) == 0) begin
                  chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
               end else begin
                  er = r ? exp_rsp1.pop_front() : exp_rsp0.pop_front();
                  chk(r ? "rsp1" : "rsp0", {20'd0, rsp_res, rsp_flags}, {20'd0, er});
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds current req_valid until every expected grant has been taken, then drops it.
   task automatic run_until_granted(input int budget);
      int n = 0;
      while (exp_grant.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("grant_timeout", {31'd0, exp_grant.size() != 0}, 32'd0);
      req_valid = 2'b00;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((busy || rsp_valid != 2'b00) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
      step();
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      req0_a = 8'd5;  req0_b = 8'd5; req0_func = 4'd1;
      req1_a = 8'hFF; req1_b = 8'd1; req1_func = 4'd3;

      // 1: reset with both valid
      repeat (3) begin
         @(negedge clk);
         chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
         chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      step();
      exp_grant.push_back(0);
      exp_rsp0.push_back({8'h00, 4'b1000});
      rst = 1'b0;
      step();
      req_valid = 2'b00;
      wait_idle(20);

      // 2: single request from requester 0, XOR to zero
      rsp_ready = 2'b01;
      exp_grant.push_back(0);
      exp_rsp0.push_back({8'h00, 4'b1000});
      req_valid = 2'b01;
      @(negedge clk);
      chk("s2_req_ready", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      @(negedge clk);
      chk("s2_exec_busy", {31'd0, busy}, 32'd1);
      chk("s2_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("s2_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      chk("s2_rsp_res", {24'd0, rsp_res}, 32'h00);
      chk("s2_rsp_flags", {28'd0, rsp_flags}, 32'b1000);
      @(negedge clk);
      chk("s2_busy_after", {31'd0, busy}, 32'd0);
      step();

      // 3: both continuously valid; prio is 1 after the last grant to requester 0
      req0_a = 8'd5;  req0_b = 8'd5; req0_func = 4'd3;
      req1_a = 8'hFF; req1_b = 8'd1; req1_func = 4'd3;
      rsp_ready = 2'b11;
      for (int i = 0; i < 2; i++) begin
         exp_grant.push_back(1);
         exp_grant.push_back(0);
         exp_rsp1.push_back({8'h00, 4'b1010});
         exp_rsp0.push_back({8'h0A, 4'b0000});
      end
      req_valid = 2'b11;
      run_until_granted(100);
      wait_idle(20);

      // 4: backpressure on requester 1 while requester 0 waits
      rsp_ready = 2'b00;
      req1_a = 8'h30; req1_b = 8'h0F; req1_func = 4'd1;
      exp_grant.push_back(1);
      exp_rsp1.push_back({8'h3F, 4'b0000});
      req_valid = 2'b10;
      step();
      req0_a = 8'h70; req0_b = 8'h20; req0_func = 4'd3;
      exp_grant.push_back(0);
      exp_rsp0.push_back({8'h90, 4'b0001});
      req_valid = 2'b01;
      req1_a = 8'h00; req1_b = 8'h00;
      step();
      repeat (5) begin
         @(negedge clk);
         chk("s4_rsp_valid", {30'd0, rsp_valid}, 32'd2);
         chk("s4_rsp_res", {24'd0, rsp_res}, 32'h3F);
         chk("s4_req_ready", {30'd0, req_ready}, 32'd0);
         step();
         rsp_ready[0] = ~rsp_ready[0];
      end
      rsp_ready = 2'b10;
      @(negedge clk);
      chk("s4_release_valid", {30'd0, rsp_valid}, 32'd2);
      step();
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("s4_done_valid", {30'd0, rsp_valid}, 32'd0);
      step();
      run_until_granted(20);
      wait_idle(20);

      // 5a: reset while in EXEC (prio is 1 after accept of requester 0)
      req0_a = 8'd5; req0_b = 8'd5; req0_func = 4'd1;
      exp_grant.push_back(0);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("s5_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("s5_exec_busy", {31'd0, busy}, 32'd0);
      chk("s5_exec_alu_a", {24'd0, alu_a}, 32'd0);
      step();
      exp_grant.push_back(0);
      exp_rsp0.push_back({8'h00, 4'b1000});
      req_valid = 2'b11;
      run_until_granted(20);
      wait_idle(20);

      // 5b: reset while in RESP
      rsp_ready = 2'b00;
      req1_a = 8'h30; req1_b = 8'h0F; req1_func = 4'd1;
      exp_grant.push_back(1);
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("s5_resp_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("s5_resp_busy", {31'd0, busy}, 32'd0);
      chk("s5_resp_alu_a", {24'd0, alu_a}, 32'd0);
      repeat (5) step();

`ifdef ALU_PERF_CNT_EN
      // 6: perf counters
      rst = 1'b1;
      step();
      rst = 1'b0;
      req0_a = 8'd5;  req0_b = 8'd5; req0_func = 4'd3;
      req1_a = 8'hFF; req1_b = 8'd1; req1_func = 4'd3;
      for (int i = 0; i < 5; i++) begin
         exp_grant.push_back(0);
         exp_grant.push_back(1);
         exp_rsp0.push_back({8'h0A, 4'b0000});
         exp_rsp1.push_back({8'h00, 4'b1010});
      end
      req_valid = 2'b11;
      run_until_granted(200);
      wait_idle(20);
      chk("perf_ops_10", {16'd0, perf_ops}, 32'd10);
      chk("perf_conflicts_10", {16'd0, perf_conflicts}, 32'd10);
      force dut.perf_ops_reg = 16'hFFFE;
      step();
      release dut.perf_ops_reg;
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      exp_grant.push_back(0);
      exp_rsp0.push_back({8'h0A, 4'b0000});
      exp_rsp1.push_back({8'h00, 4'b1010});
      exp_rsp0.push_back({8'h0A, 4'b0000});
      req_valid = 2'b11;
      run_until_granted(200);
      wait_idle(20);
      chk("perf_ops_sat", {16'd0, perf_ops}, 32'hFFFF);
      chk("perf_conflicts_13", {16'd0, perf_conflicts}, 32'd13);
`endif

      chk("grant_queue_empty", exp_grant.size(), 32'd0);
      chk("rsp0_queue_empty", exp_rsp0.size(), 32'd0);
      chk("rsp1_queue_empty", exp_rsp1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
